// File: rtl/mem_loader_responder.sv
// Memory-side responder: single-port word memory serving the CPU bus, preceded by a
// streaming loader that fills the program image and then releases the CPU from reset.
module mem_loader_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] mem_in,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] BASE = (ADDR_WIDTH+1)'(LOAD_BASE);
  localparam logic [ADDR_WIDTH:0] TOP  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_in_q, mem_in_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  load_done_q, load_done_d;
  logic                  load_err_q, load_err_d;
  logic [ADDR_WIDTH:0]   load_count_q, load_count_d;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   ld_addr;
  logic                  xfer;

  // Loader handshake: a word moves on a rising edge where ld_valid && ld_ready;
  // ld_ready depends only on state, never on ld_valid, and ld_last is ignored unless ld_valid.
  assign ld_ready = (state_q == S_LOAD);
  assign xfer     = ld_valid && ld_ready;
  assign ld_addr  = BASE + load_count_q;

  always_comb begin
    state_d      = state_q;
    mem_in_d     = '0;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    wr_en        = 1'b0;
    wr_addr      = mem_addr;
    wr_data      = mem_data;
    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          wr_en        = 1'b1;
          wr_addr      = ld_addr[ADDR_WIDTH-1:0];
          wr_data      = ld_data;
          load_count_d = load_count_q + (ADDR_WIDTH+1)'(1);
          if (ld_last) begin
            state_d = S_RELEASE;
          end else if (ld_addr == TOP) begin
            // Image reached the last word without ld_last: stop rather than wrap.
            state_d    = S_RELEASE;
            load_err_d = 1'b1;
          end
        end
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        mem_in_d = mem[mem_addr];
        wr_en    = mem_we;
      end
      default: state_d = S_LOAD;
    endcase
    cpu_rst_n_d = (state_d == S_RUN);
    load_done_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      mem_in_q     <= '0;
      cpu_rst_n_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_in_q     <= mem_in_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      load_count_q <= load_count_d;
    end
  end

  // Array is not reset so an image survives a reset pulse; reads above see the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign mem_in     = mem_in_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign load_count = load_count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_loader_responder.sv
// Directed bench for mem_loader_responder: load, gapped load, overflow, CPU access, resets.
module tb_mem_loader_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_in;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_err;
  logic [6:0]  load_count;
  logic [1:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  mem_loader_responder #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LOAD_BASE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err),
    .load_count(load_count), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs changed afterwards are stable by the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset pulse placed between edges; checks the reset state while held.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
    chk({tag, "_load_count"}, 32'(load_count), 32'h0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'h1);
    chk({tag, "_mem_in"}, 32'(mem_in), 32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cpu_read(input string tag, input logic [5:0] a, input logic [15:0] exp);
    mem_we   = 1'b0;
    mem_addr = a;
    step();
    chk(tag, 32'(mem_in), 32'(exp));
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [15:0] d);
    mem_we   = 1'b1;
    mem_addr = a;
    mem_data = d;
    step();
    mem_we   = 1'b0;
  endtask

  logic [15:0] img [3];

  initial begin
    img[0] = 16'h7000; img[1] = 16'h8000; img[2] = 16'hF000;
    rst_n = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_data = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #12;
    chk("rst_mem_in", 32'(mem_in), 32'h0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);
    chk("rst_load_count", 32'(load_count), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h1);
    rst_n = 1'b1;
    step();

    // T1: back-to-back load of three words
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 2);
      step();
      chk("t1_count", 32'(load_count), 32'(i + 1));
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("t1_release_ready", 32'(ld_ready), 32'h0);
    chk("t1_release_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("t1_release_done", 32'(load_done), 32'h0);
    step();
    chk("t1_run_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("t1_run_done", 32'(load_done), 32'h1);
    chk("t1_run_err", 32'(load_err), 32'h0);
    chk("t1_run_count", 32'(load_count), 32'h3);
    for (int i = 0; i < 3; i++) cpu_read("t1_mem", 6'(8 + i), img[i]);

    // T4: RUN write then read, and read-first on simultaneous access
    cpu_write(6'd5, 16'hABCD);
    cpu_read("t4_read_after_write", 6'd5, 16'hABCD);
    cpu_write(6'd5, 16'h1234);
    chk("t4_read_first_old", 32'(mem_in), 32'hABCD);
    cpu_read("t4_read_new", 6'd5, 16'h1234);
    cpu_write(6'd20, 16'h0000);

    // T5 + T2: CPU write ignored in LOAD, then gapped load
    pulse_reset("t2_reset");
    step();
    cpu_write(6'd20, 16'hDEAD);
    chk("t5_load_mem_in", 32'(mem_in), 32'h0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 2);
      step();
      chk("t2_count_valid", 32'(load_count), 32'(i + 1));
      ld_valid = 1'b0; ld_last = 1'b0; ld_data = 16'hFFFF;
      step();
      step();
      chk("t2_count_gap", 32'(load_count), 32'(i + 1));
    end
    chk("t2_done", 32'(load_done), 32'h1);
    for (int i = 0; i < 3; i++) cpu_read("t2_mem", 6'(8 + i), img[i]);
    cpu_read("t5_no_load_write", 6'd20, 16'h0000);

    // T3: 56 words with no ld_last run into the top of memory
    pulse_reset("t3_reset");
    step();
    for (int i = 1; i <= 56; i++) begin
      ld_valid = 1'b1; ld_data = 16'(i); ld_last = 1'b0;
      step();
      if (i == 55) begin
        chk("t3_count_55", 32'(load_count), 32'd55);
        chk("t3_err_55", 32'(load_err), 32'h0);
      end
    end
    chk("t3_count", 32'(load_count), 32'd56);
    chk("t3_err", 32'(load_err), 32'h1);
    chk("t3_ready_release", 32'(ld_ready), 32'h0);
    ld_data = 16'hBEEF;
    step();
    chk("t3_run_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("t3_ready_run", 32'(ld_ready), 32'h0);
    step();
    chk("t3_count_frozen", 32'(load_count), 32'd56);
    chk("t3_err_sticky", 32'(load_err), 32'h1);
    ld_valid = 1'b0;
    cpu_read("t3_mem63", 6'd63, 16'h0038);
    cpu_read("t3_mem8", 6'd8, 16'h0001);

    // T6: reset mid-load keeps old words, new load overwrites from the base
    pulse_reset("t6_reset_a");
    step();
    ld_valid = 1'b1; ld_data = 16'h1111; ld_last = 1'b0;
    step();
    ld_data = 16'h2222;
    step();
    chk("t6_count_2", 32'(load_count), 32'h2);
    ld_valid = 1'b0;
    pulse_reset("t6_reset_b");
    step();
    chk("t6_err_cleared", 32'(load_err), 32'h0);
    ld_valid = 1'b1; ld_data = 16'h5555; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    step();
    chk("t6_done", 32'(load_done), 32'h1);
    chk("t6_count_1", 32'(load_count), 32'h1);
    cpu_read("t6_mem8_new", 6'd8, 16'h5555);
    cpu_read("t6_mem9_old", 6'd9, 16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
